// File: rtl/operand_loader_pkg.sv
// Shared definitions for the operand loader: default sizes and the entry FSM state encoding.
package operand_loader_pkg;

  localparam int N_DEF        = 32;
  localparam int DEPTH_DEF    = 8;
  localparam int AW_DEF       = 3;
  localparam int DEBOUNCE_DEF = 500000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_FULL,
    ST_WRITE
  } state_e;

endpackage

// File: rtl/operand_loader_btn_debounce.sv
// Raw active-low push-button conditioner: 2-FF synchronizer, level debouncer and
// a single-cycle pulse on each accepted press.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic btn_ni,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic [1:0]    sync_q;
  logic          level_q;
  logic [CW-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_o <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_ni};
      press_o <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
        // The new level has now been seen DEBOUNCE_CYC times in a row.
        level_q <= sync_q[1];
        cnt_q   <= '0;
        press_o <= ~sync_q[1];
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/operand_loader.sv
// Operand loader: keys N-bit operands a nibble at a time and commits them into two
// DEPTH-entry register banks with combinational read ports for the ALU datapath.
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int N            = N_DEF,
  parameter int DEPTH        = DEPTH_DEF,
  parameter int AW           = AW_DEF,
  parameter int DEBOUNCE_CYC = DEBOUNCE_DEF
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic [3:0]    sw_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic          wr_bank_i,
  input  logic          btn_load_ni,
  input  logic          btn_commit_ni,
  input  logic          btn_clear_ni,
  input  logic [AW-1:0] addra_i,
  input  logic [AW-1:0] addrb_i,
  output logic [N-1:0]  dato_a_o,
  output logic [N-1:0]  dato_b_o,
  output logic [N-1:0]  shadow_o,
  output logic [3:0]    count_o,
  output logic          err_o,
  output logic          wr_done_o
);

  localparam logic [3:0] FULL_CNT = 4'(N / 4);

  logic load_p, commit_p, clear_p;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_load (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .btn_ni(btn_load_ni), .press_o(load_p));
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_commit (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .btn_ni(btn_commit_ni), .press_o(commit_p));
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_clear (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .btn_ni(btn_clear_ni), .press_o(clear_p));

  state_e          state_q, state_d;
  logic [N-1:0]    shadow_q, shadow_d;
  logic [3:0]      count_q, count_d;
  logic            err_q, err_d;
  logic            capture;
  logic [AW-1:0]   wr_addr_q;
  logic            wr_bank_q;
  logic [N-1:0]    bank_a [DEPTH];
  logic [N-1:0]    bank_b [DEPTH];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      shadow_q  <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      wr_addr_q <= '0;
      wr_bank_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      count_q  <= count_d;
      err_q    <= err_d;
      if (capture) begin
        wr_addr_q <= wr_addr_i;
        wr_bank_q <= wr_bank_i;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    count_d  = count_q;
    err_d    = err_q;
    capture  = 1'b0;
    if (state_q == ST_WRITE) begin
      // The write happens at the end of this cycle; button pulses are ignored here.
      state_d  = ST_IDLE;
      shadow_d = '0;
      count_d  = '0;
      err_d    = 1'b0;
    end else if (clear_p) begin
      state_d  = ST_IDLE;
      shadow_d = '0;
      count_d  = '0;
      err_d    = 1'b0;
    end else if (commit_p) begin
      if (state_q == ST_IDLE) begin
        err_d = 1'b1;
      end else begin
        state_d = ST_WRITE;
        capture = 1'b1;
      end
    end else if (load_p) begin
      if (state_q == ST_FULL) begin
        err_d = 1'b1;
      end else begin
        shadow_d = {shadow_q[N-5:0], sw_i};
        count_d  = count_q + 4'd1;
        state_d  = (count_q + 4'd1 == FULL_CNT) ? ST_FULL : ST_ENTRY;
      end
    end
  end

  // NOTE: the banks are ordinary flops, so they are explicitly cleared by reset like any other state.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank_a[i] <= '0;
        bank_b[i] <= '0;
      end
    end else if (state_q == ST_WRITE) begin
      if (wr_bank_q) bank_b[wr_addr_q] <= shadow_q;
      else           bank_a[wr_addr_q] <= shadow_q;
    end
  end

  assign dato_a_o  = bank_a[addra_i];
  assign dato_b_o  = bank_b[addrb_i];
  assign shadow_o  = shadow_q;
  assign count_o   = count_q;
  assign err_o     = err_q;
  assign wr_done_o = (state_q == ST_WRITE);

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader with a short debounce window; outputs sampled on the falling edge.
module tb_operand_loader;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [3:0]  sw_i;
  logic [2:0]  wr_addr_i;
  logic        wr_bank_i;
  logic        btn_load_ni, btn_commit_ni, btn_clear_ni;
  logic [2:0]  addra_i, addrb_i;
  logic [31:0] dato_a_o, dato_b_o, shadow_o;
  logic [3:0]  count_o;
  logic        err_o, wr_done_o;

  int n_cmp = 0;
  int n_mis = 0;
  int done_cnt = 0;

  always #5 clk_i = ~clk_i;

  operand_loader #(.N(32), .DEPTH(8), .AW(3), .DEBOUNCE_CYC(4)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .sw_i(sw_i), .wr_addr_i(wr_addr_i), .wr_bank_i(wr_bank_i),
    .btn_load_ni(btn_load_ni), .btn_commit_ni(btn_commit_ni), .btn_clear_ni(btn_clear_ni),
    .addra_i(addra_i), .addrb_i(addrb_i), .dato_a_o(dato_a_o), .dato_b_o(dato_b_o),
    .shadow_o(shadow_o), .count_o(count_o), .err_o(err_o), .wr_done_o(wr_done_o));

  always @(negedge clk_i) if (wr_done_o === 1'b1) done_cnt++;

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic load_nib(input logic [3:0] v);
    sw_i = v; btn_load_ni = 1'b0; tick(10); btn_load_ni = 1'b1; tick(10);
  endtask

  task automatic commit_to(input logic [2:0] a, input logic b);
    wr_addr_i = a; wr_bank_i = b; btn_commit_ni = 1'b0; tick(10); btn_commit_ni = 1'b1; tick(10);
  endtask

  task automatic clear_press();
    btn_clear_ni = 1'b0; tick(10); btn_clear_ni = 1'b1; tick(10);
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; tick(2);
    n_cmp++; if (shadow_o !== 32'h0) begin n_mis++; $display("FAIL rst_shadow: got %h want 0", shadow_o); end
    n_cmp++; if (count_o !== 4'h0) begin n_mis++; $display("FAIL rst_count: got %0d want 0", count_o); end
    n_cmp++; if (err_o !== 1'b0) begin n_mis++; $display("FAIL rst_err: got %b want 0", err_o); end
    n_cmp++; if (wr_done_o !== 1'b0) begin n_mis++; $display("FAIL rst_wr_done: got %b want 0", wr_done_o); end
    rst_n_i = 1'b1; tick(2);
  endtask

  task automatic test_full_commit();
    int d0;
    for (int i = 1; i <= 8; i++) load_nib(4'(i));
    n_cmp++; if (shadow_o !== 32'h12345678) begin n_mis++; $display("FAIL full_shadow: got %h want 12345678", shadow_o); end
    n_cmp++; if (count_o !== 4'd8) begin n_mis++; $display("FAIL full_count: got %0d want 8", count_o); end
    d0 = done_cnt;
    commit_to(3'd3, 1'b0);
    addra_i = 3'd3; #1;
    n_cmp++; if (done_cnt - d0 !== 1) begin n_mis++; $display("FAIL full_wr_done_pulses: got %0d want 1", done_cnt - d0); end
    n_cmp++; if (dato_a_o !== 32'h12345678) begin n_mis++; $display("FAIL full_bank_a3: got %h want 12345678", dato_a_o); end
    n_cmp++; if (count_o !== 4'd0) begin n_mis++; $display("FAIL full_count_after: got %0d want 0", count_o); end
    n_cmp++; if (shadow_o !== 32'h0) begin n_mis++; $display("FAIL full_shadow_after: got %h want 0", shadow_o); end
  endtask

  task automatic test_partial();
    load_nib(4'hA); load_nib(4'hB); load_nib(4'hC);
    n_cmp++; if (count_o !== 4'd3) begin n_mis++; $display("FAIL part_count: got %0d want 3", count_o); end
    commit_to(3'd7, 1'b1);
    addrb_i = 3'd7; #1;
    n_cmp++; if (dato_b_o !== 32'h00000ABC) begin n_mis++; $display("FAIL part_bank_b7: got %h want 00000abc", dato_b_o); end
    n_cmp++; if (count_o !== 4'd0) begin n_mis++; $display("FAIL part_count_after: got %0d want 0", count_o); end
  endtask

  task automatic test_err();
    int d0;
    for (int i = 8; i >= 1; i--) load_nib(4'(i));
    load_nib(4'hF);
    n_cmp++; if (err_o !== 1'b1) begin n_mis++; $display("FAIL err_overload: got %b want 1", err_o); end
    n_cmp++; if (shadow_o !== 32'h87654321) begin n_mis++; $display("FAIL err_shadow_kept: got %h want 87654321", shadow_o); end
    commit_to(3'd0, 1'b0);
    addra_i = 3'd0; #1;
    n_cmp++; if (err_o !== 1'b0) begin n_mis++; $display("FAIL err_cleared_by_commit: got %b want 0", err_o); end
    n_cmp++; if (dato_a_o !== 32'h87654321) begin n_mis++; $display("FAIL err_bank_a0: got %h want 87654321", dato_a_o); end
    d0 = done_cnt;
    commit_to(3'd1, 1'b0);
    addra_i = 3'd1; #1;
    n_cmp++; if (err_o !== 1'b1) begin n_mis++; $display("FAIL err_idle_commit: got %b want 1", err_o); end
    n_cmp++; if (done_cnt !== d0) begin n_mis++; $display("FAIL err_idle_no_write: got %0d pulses want 0", done_cnt - d0); end
    n_cmp++; if (dato_a_o !== 32'h0) begin n_mis++; $display("FAIL err_idle_bank_a1: got %h want 0", dato_a_o); end
    clear_press();
    n_cmp++; if (err_o !== 1'b0) begin n_mis++; $display("FAIL err_cleared_by_clear: got %b want 0", err_o); end
  endtask

  task automatic test_bounce();
    sw_i = 4'h5;
    for (int i = 0; i < 4; i++) begin
      btn_load_ni = 1'b0; tick(2); btn_load_ni = 1'b1; tick(3);
    end
    tick(10);
    n_cmp++; if (count_o !== 4'd0) begin n_mis++; $display("FAIL bounce_count: got %0d want 0", count_o); end
    n_cmp++; if (shadow_o !== 32'h0) begin n_mis++; $display("FAIL bounce_shadow: got %h want 0", shadow_o); end
  endtask

  task automatic test_clear_commit();
    int d0;
    load_nib(4'h4);
    n_cmp++; if (shadow_o !== 32'h4) begin n_mis++; $display("FAIL cc_shadow_before: got %h want 4", shadow_o); end
    d0 = done_cnt;
    wr_addr_i = 3'd2; wr_bank_i = 1'b1;
    btn_clear_ni = 1'b0; btn_commit_ni = 1'b0; tick(10);
    btn_clear_ni = 1'b1; btn_commit_ni = 1'b1; tick(10);
    addrb_i = 3'd2; #1;
    n_cmp++; if (count_o !== 4'd0) begin n_mis++; $display("FAIL cc_count: got %0d want 0", count_o); end
    n_cmp++; if (shadow_o !== 32'h0) begin n_mis++; $display("FAIL cc_shadow: got %h want 0", shadow_o); end
    n_cmp++; if (done_cnt !== d0) begin n_mis++; $display("FAIL cc_no_write: got %0d pulses want 0", done_cnt - d0); end
    n_cmp++; if (dato_b_o !== 32'h0) begin n_mis++; $display("FAIL cc_bank_b2: got %h want 0", dato_b_o); end
    n_cmp++; if (err_o !== 1'b0) begin n_mis++; $display("FAIL cc_err: got %b want 0", err_o); end
  endtask

  task automatic test_read_during_write();
    bit seen = 1'b0;
    load_nib(4'h9); load_nib(4'h9);
    addra_i = 3'd3; wr_addr_i = 3'd3; wr_bank_i = 1'b0;
    btn_commit_ni = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk_i);
      if (wr_done_o === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_mis++; $display("FAIL rdw_timeout: got no wr_done_o within 30 cycles want pulse");
    end else begin
      n_cmp++; if (dato_a_o !== 32'h12345678) begin n_mis++; $display("FAIL rdw_old: got %h want 12345678", dato_a_o); end
      tick(1);
      n_cmp++; if (dato_a_o !== 32'h00000099) begin n_mis++; $display("FAIL rdw_new: got %h want 00000099", dato_a_o); end
      n_cmp++; if (wr_done_o !== 1'b0) begin n_mis++; $display("FAIL rdw_pulse_len: got %b want 0", wr_done_o); end
    end
    btn_commit_ni = 1'b1; tick(10);
  endtask

  task automatic test_mid_reset();
    load_nib(4'h7);
    n_cmp++; if (count_o !== 4'd1) begin n_mis++; $display("FAIL mrst_count_before: got %0d want 1", count_o); end
    rst_n_i = 1'b0; tick(1);
    n_cmp++; if (shadow_o !== 32'h0) begin n_mis++; $display("FAIL mrst_shadow: got %h want 0", shadow_o); end
    n_cmp++; if (count_o !== 4'd0) begin n_mis++; $display("FAIL mrst_count: got %0d want 0", count_o); end
    for (int i = 0; i < 8; i++) begin
      addra_i = 3'(i); addrb_i = 3'(i); #1;
      n_cmp++; if (dato_a_o !== 32'h0) begin n_mis++; $display("FAIL mrst_bank_a%0d: got %h want 0", i, dato_a_o); end
      n_cmp++; if (dato_b_o !== 32'h0) begin n_mis++; $display("FAIL mrst_bank_b%0d: got %h want 0", i, dato_b_o); end
    end
    rst_n_i = 1'b1; tick(2);
  endtask

  initial begin
    rst_n_i = 1'b0; sw_i = 4'h0; wr_addr_i = 3'd0; wr_bank_i = 1'b0;
    btn_load_ni = 1'b1; btn_commit_ni = 1'b1; btn_clear_ni = 1'b1;
    addra_i = 3'd0; addrb_i = 3'd0;
    test_reset();
    test_full_commit();
    test_partial();
    test_err();
    test_bounce();
    test_clear_commit();
    test_read_during_write();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
